// File: rtl/bayer_pkg.sv
// Shared Bayer definitions: CFA pattern codes and a byte-rounding width helper.
// Used by both the mosaicing and the demosaicing blocks.
package bayer_pkg;

    typedef enum logic [1:0] {
        GBRG = 2'b00,
        BGGR = 2'b01,
        GRBG = 2'b10,
        RGGB = 2'b11
    } bayer_pattern_e;

    function automatic int byte_round(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream video bundle; tuser marks start of frame, tlast marks end of line.
// Width parameters let the same interface carry RGB and raw Bayer video.
interface axi4_stream_if #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
);

    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [DATA_W/8-1:0] tstrb;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic                tuser;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;

    modport master (
        output tdata, tkeep, tstrb, tvalid, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tstrb, tvalid, tlast, tuser, tid, tdest,
        output tready
    );

endinterface

// File: rtl/demosaicing_ctrl_if.sv
// Control bundle shared by the Bayer mosaicing and demosaicing blocks:
// CFA pattern code and enable.
interface demosaicing_ctrl_if;

    logic [1:0] pattern;
    logic       en;

    modport master (output pattern, output en);
    modport slave  (input  pattern, input  en);

endinterface

// File: rtl/bayer_phase_tracker.sv
// Tracks pixel/line parity within a frame and latches pattern/enable at
// every start-of-frame beat; flags whether the current beat is R/B and on an R line.
module bayer_phase_tracker
    import bayer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       beat_i,
    input  logic       sof_i,
    input  logic       eol_i,
    input  logic [1:0] pattern_i,
    input  logic       en_i,
    output logic       en_o,
    output logic       line_is_r_o,
    output logic       px_non_g_o
);

    logic [1:0] pat_q;
    logic       en_q;
    logic       px_par_q;
    logic       line_par_q;

    logic [1:0] pat_c;
    logic       px_c;
    logic       line_c;

    // A start-of-frame beat uses its own control and restarts parity at once
    always_comb begin
        pat_c       = sof_i ? pattern_i : pat_q;
        en_o        = sof_i ? en_i : en_q;
        px_c        = sof_i ? 1'b0 : px_par_q;
        line_c      = sof_i ? 1'b0 : line_par_q;
        line_is_r_o = pat_c[1] ^ line_c;
        px_non_g_o  = pat_c[0] ^ px_c ^ line_c;
    end

    // Advance parity and latch control only on accepted beats
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pat_q      <= GBRG;
            en_q       <= 1'b0;
            px_par_q   <= 1'b0;
            line_par_q <= 1'b0;
        end else if (beat_i) begin
            if (sof_i) begin
                pat_q <= pattern_i;
                en_q  <= en_i;
            end
            px_par_q   <= eol_i ? 1'b0 : ~px_c;
            line_par_q <= eol_i ? ~line_c : line_c;
        end
    end

endmodule

// File: rtl/bayer_mosaicing.sv
// RGB to Bayer raw converter: two-register pipeline with full backpressure.
// Define BAYER_MOSAICING_LUMA_EN to make bypass output (R+2G+B)/4 instead of G.
module bayer_mosaicing
    import bayer_pkg::*;
#(
    parameter int RAW_PX_WIDTH = 10,
    parameter int FRAME_RES_X  = 1920,
    parameter int FRAME_RES_Y  = 1080
) (
    input logic               clk_i,
    input logic               rst_i,
    demosaicing_ctrl_if.slave mosaicing_ctrl_i,
    axi4_stream_if.slave      rgb_video_i,
    axi4_stream_if.master     raw_video_o
);

    localparam int W     = RAW_PX_WIDTH;
    localparam int OUT_W = byte_round(W);

    logic [W-1:0] px_g;
    logic [W-1:0] px_b;
    logic [W-1:0] px_r;
    logic         beat;
    logic         in_ready;
    logic         s2_ready;
    logic         en_eff;
    logic         line_is_r;
    logic         px_non_g;
    logic [W-1:0] sel;

    logic         s1_valid;
    logic         s1_last;
    logic         s1_user;
    logic [W-1:0] s1_data;
    logic [W-1:0] s2_data;

`ifdef BAYER_MOSAICING_LUMA_EN
    logic         s1_byp;
    logic [W+1:0] s1_sum;
    logic [W+1:0] sum;
`endif

    logic unused_ok;

    assign px_g = rgb_video_i.tdata[W-1:0];
    assign px_b = rgb_video_i.tdata[2*W-1:W];
    assign px_r = rgb_video_i.tdata[3*W-1:2*W];

    assign s2_ready = !raw_video_o.tvalid || raw_video_o.tready;
    assign in_ready = !s1_valid || s2_ready;
    assign beat     = rgb_video_i.tvalid && in_ready;

    assign rgb_video_i.tready = in_ready;

    assign raw_video_o.tkeep = '1;
    assign raw_video_o.tstrb = '1;
    assign raw_video_o.tid   = '0;
    assign raw_video_o.tdest = '0;

    assign unused_ok = &{1'b0, rgb_video_i.tdata, rgb_video_i.tkeep,
                         rgb_video_i.tstrb, rgb_video_i.tid,
                         rgb_video_i.tdest, FRAME_RES_X > 0,
                         FRAME_RES_Y > 0};

    bayer_phase_tracker u_phase (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .beat_i      (beat),
        .sof_i       (rgb_video_i.tuser),
        .eol_i       (rgb_video_i.tlast),
        .pattern_i   (mosaicing_ctrl_i.pattern),
        .en_i        (mosaicing_ctrl_i.en),
        .en_o        (en_eff),
        .line_is_r_o (line_is_r),
        .px_non_g_o  (px_non_g)
    );

    // Pick the CFA sample for this site; G doubles as the plain bypass value
    always_comb begin
        sel = px_g;
        if (en_eff && px_non_g) begin
            sel = line_is_r ? px_r : px_b;
        end
    end

`ifdef BAYER_MOSAICING_LUMA_EN
    assign sum = (W+2)'(px_r) + (W+2)'({px_g, 1'b0}) + (W+2)'(px_b);
    assign s2_data = s1_byp ? s1_sum[W+1:2] : s1_data;
`else
    assign s2_data = s1_data;
`endif

    // Stage 1: capture selection on accept, drain when stage 2 takes it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_user  <= 1'b0;
            s1_data  <= '0;
`ifdef BAYER_MOSAICING_LUMA_EN
            s1_byp   <= 1'b0;
            s1_sum   <= '0;
`endif
        end else begin
            if (in_ready) begin
                s1_valid <= rgb_video_i.tvalid;
            end
            if (beat) begin
                s1_last <= rgb_video_i.tlast;
                s1_user <= rgb_video_i.tuser;
                s1_data <= sel;
`ifdef BAYER_MOSAICING_LUMA_EN
                s1_byp  <= !en_eff;
                s1_sum  <= sum;
`endif
            end
        end
    end

    // Stage 2: output register, held while the sink stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            raw_video_o.tvalid <= 1'b0;
            raw_video_o.tlast  <= 1'b0;
            raw_video_o.tuser  <= 1'b0;
            raw_video_o.tdata  <= '0;
        end else if (s2_ready) begin
            raw_video_o.tvalid <= s1_valid;
            if (s1_valid) begin
                raw_video_o.tlast <= s1_last;
                raw_video_o.tuser <= s1_user;
                raw_video_o.tdata <= OUT_W'(s2_data);
            end
        end
    end

endmodule

// File: tb/tb_bayer_mosaicing.sv
// Directed bench for bayer_mosaicing: 4x2 frames in all patterns, bypass,
// mid-frame control change, reset while busy, and random output backpressure.
module tb_bayer_mosaicing;
    import bayer_pkg::*;

    localparam int W      = 10;
    localparam int IN_W   = byte_round(3 * W);
    localparam int OUT_W  = byte_round(W);
    localparam int N_RAND = 1000;

`ifdef BAYER_MOSAICING_LUMA_EN
    localparam logic [W-1:0] BYP = 10'h1FF;
`else
    localparam logic [W-1:0] BYP = 10'h000;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demosaicing_ctrl_if ctrl ();
    axi4_stream_if #(.DATA_W(IN_W))  rgb ();
    axi4_stream_if #(.DATA_W(OUT_W)) raw ();

    bayer_mosaicing #(
        .RAW_PX_WIDTH (W),
        .FRAME_RES_X  (4),
        .FRAME_RES_Y  (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mosaicing_ctrl_i (ctrl),
        .rgb_video_i      (rgb),
        .raw_video_o      (raw)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic u, input logic l,
                         input logic [W-1:0] r, input logic [W-1:0] g,
                         input logic [W-1:0] b);
        rgb.tvalid = v;
        rgb.tuser  = u;
        rgb.tlast  = l;
        rgb.tdata  = IN_W'({r, b, g});
    endtask

    // Independent model: 2x2 CFA tile lookup, 0=G 1=R 2=B
    function automatic logic [W-1:0] ref_px(input logic [1:0] pat,
                                            input logic en, input int line,
                                            input int px,
                                            input logic [W-1:0] r,
                                            input logic [W-1:0] g,
                                            input logic [W-1:0] b);
        int t[4];
        int c;
        if (!en) begin
`ifdef BAYER_MOSAICING_LUMA_EN
            return W'((int'(r) + 2 * int'(g) + int'(b)) >> 2);
`else
            return g;
`endif
        end
        case (pat)
            2'b00:   t = '{0, 2, 1, 0};
            2'b01:   t = '{2, 0, 0, 1};
            2'b10:   t = '{0, 1, 2, 0};
            default: t = '{1, 0, 0, 2};
        endcase
        c = t[(line % 2) * 2 + (px % 2)];
        return (c == 0) ? g : ((c == 1) ? r : b);
    endfunction

    task automatic run_frame(input string tag, input logic [1:0] p0,
                             input logic [1:0] p1, input logic en,
                             input logic [W-1:0] r, input logic [W-1:0] g,
                             input logic [W-1:0] b,
                             input logic [W-1:0] e[8]);
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                ctrl.pattern = (j < 4) ? p0 : p1;
                ctrl.en      = en;
                drive(1'b1, j == 0, j % 4 == 3, r, g, b);
            end else begin
                drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
            end
            @(posedge clk);
            #1;
            if (j == 0 || j == 9) begin
                chk({tag, $sformatf(".idle%0d", j)}, 32'(raw.tvalid), 32'd0);
            end else begin
                chk({tag, $sformatf(".valid%0d", j - 1)},
                    32'(raw.tvalid), 32'd1);
                chk({tag, $sformatf(".data%0d", j - 1)},
                    32'(raw.tdata), 32'(e[j-1]));
                chk({tag, $sformatf(".flags%0d", j - 1)},
                    32'({raw.tuser, raw.tlast}),
                    32'({j == 1, (j - 1) % 4 == 3}));
            end
        end
    endtask

    logic [W-1:0]   cr, cg, cb;
    logic [OUT_W+1:0] held;
    logic [OUT_W+1:0] expq[$];
    logic [OUT_W+1:0] exp_w;
    logic           in_hs;
    logic           out_hs;
    logic           stall;
    logic [1:0]     fpat;
    logic           fen;
    int             in_idx;
    int             out_idx;
    int             cyc;
    int             frame;

    initial begin
        rst          = 1'b1;
        ctrl.pattern = 2'b00;
        ctrl.en      = 1'b0;
        rgb.tkeep    = '1;
        rgb.tstrb    = '1;
        rgb.tid      = '0;
        rgb.tdest    = '0;
        raw.tready   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset.tvalid", 32'(raw.tvalid), 32'd0);
        chk("reset.tdata", 32'(raw.tdata), 32'd0);
        chk("reset.flags", 32'({raw.tuser, raw.tlast}), 32'd0);
        chk("reset.tkeep", 32'(raw.tkeep), 32'h3);
        chk("reset.tid", 32'({raw.tid, raw.tdest}), 32'd0);
        rst = 1'b0;
        #1;
        chk("release.tready", 32'(rgb.tready), 32'd1);

        run_frame("rggb", RGGB, RGGB, 1'b1, 10'h300, 10'h200, 10'h100,
                  '{10'h300, 10'h200, 10'h300, 10'h200,
                    10'h200, 10'h100, 10'h200, 10'h100});
        run_frame("gbrg", GBRG, GBRG, 1'b1, 10'h300, 10'h200, 10'h100,
                  '{10'h200, 10'h100, 10'h200, 10'h100,
                    10'h300, 10'h200, 10'h300, 10'h200});
        run_frame("bggr", BGGR, BGGR, 1'b1, 10'h300, 10'h200, 10'h100,
                  '{10'h100, 10'h200, 10'h100, 10'h200,
                    10'h200, 10'h300, 10'h200, 10'h300});
        run_frame("grbg", GRBG, GRBG, 1'b1, 10'h300, 10'h200, 10'h100,
                  '{10'h200, 10'h300, 10'h200, 10'h300,
                    10'h100, 10'h200, 10'h100, 10'h200});
        run_frame("bypass", RGGB, RGGB, 1'b0, 10'h3FF, 10'h000, 10'h3FF,
                  '{BYP, BYP, BYP, BYP, BYP, BYP, BYP, BYP});
        run_frame("midchg", RGGB, BGGR, 1'b1, 10'h300, 10'h200, 10'h100,
                  '{10'h300, 10'h200, 10'h300, 10'h200,
                    10'h200, 10'h100, 10'h200, 10'h100});
        run_frame("newfrm", BGGR, BGGR, 1'b1, 10'h300, 10'h200, 10'h100,
                  '{10'h100, 10'h200, 10'h100, 10'h200,
                    10'h200, 10'h300, 10'h200, 10'h300});

        ctrl.pattern = RGGB;
        ctrl.en      = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 10'h300, 10'h200, 10'h100);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 10'h300, 10'h200, 10'h100);
        @(posedge clk);
        #1;
        chk("inflight.tvalid", 32'(raw.tvalid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.tvalid", 32'(raw.tvalid), 32'd0);
        chk("rst.tready", 32'(rgb.tready), 32'd1);
        @(posedge clk);
        #1;
        chk("rst.drained", 32'(raw.tvalid), 32'd0);

        drive(1'b1, 1'b0, 1'b1, 10'h300, 10'h200, 10'h100);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        chk("presof.tvalid", 32'(raw.tvalid), 32'd1);
        chk("presof.tdata", 32'(raw.tdata), 32'h200);
        @(posedge clk);
        #1;
        chk("presof.idle", 32'(raw.tvalid), 32'd0);

        run_frame("postrst", RGGB, RGGB, 1'b1, 10'h300, 10'h200, 10'h100,
                  '{10'h300, 10'h200, 10'h300, 10'h200,
                    10'h200, 10'h100, 10'h200, 10'h100});

        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        in_hs   = 1'b0;
        stall   = 1'b0;
        held    = '0;
        cr      = W'($urandom);
        cg      = W'($urandom);
        cb      = W'($urandom);
        while (out_idx < N_RAND && cyc < 20000) begin
            if (stall) begin
                chk("rand.hold", 32'({raw.tuser, raw.tlast, raw.tdata}),
                    32'(held));
            end
            if (in_hs) begin
                in_idx++;
                cr = W'($urandom);
                cg = W'($urandom);
                cb = W'($urandom);
            end
            frame = in_idx / 15;
            fpat  = 2'(frame % 4);
            fen   = (frame % 3) != 0;
            if (in_idx < N_RAND) begin
                ctrl.pattern = fpat;
                ctrl.en      = fen;
                drive(1'b1, in_idx % 15 == 0, in_idx % 5 == 4, cr, cg, cb);
            end else begin
                drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
            end
            raw.tready = 1'($urandom_range(0, 1));
            #1;
            in_hs = rgb.tvalid && rgb.tready;
            if (in_hs) begin
                exp_w = {in_idx % 15 == 0, in_idx % 5 == 4,
                         OUT_W'(ref_px(fpat, fen, (in_idx / 5) % 3,
                                       in_idx % 5, cr, cg, cb))};
                expq.push_back(exp_w);
            end
            out_hs = raw.tvalid && raw.tready;
            if (out_hs) begin
                if (expq.size() == 0) begin
                    chk("rand.extra", 32'd1, 32'd0);
                end else begin
                    exp_w = expq.pop_front();
                    chk($sformatf("rand.beat%0d", out_idx),
                        32'({raw.tuser, raw.tlast, raw.tdata}), 32'(exp_w));
                end
                out_idx++;
            end
            stall = raw.tvalid && !raw.tready;
            held  = {raw.tuser, raw.tlast, raw.tdata};
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rand.count", 32'(out_idx), 32'(N_RAND));
        chk("rand.leftover", 32'(expq.size()), 32'd0);
        raw.tready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rand.idle", 32'(raw.tvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bayer_mosaicing.md
BAYER_MOSAICING -- requirements
Module: bayer_mosaicing

Interface
REQ-001 SHALL have parameter RAW_PX_WIDTH, default 10, meaning the per-channel and raw pixel width in bits.
REQ-002 SHALL have parameter FRAME_RES_X, default 1920, meaning active pixels per line (documentation and bench only, no RTL dependence).
REQ-003 SHALL have parameter FRAME_RES_Y, default 1080, meaning active lines per frame (documentation and bench only).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, the asynchronous active-high reset.
REQ-006 SHALL have port mosaicing_ctrl_i, demosaicing_ctrl_if.slave, -, carrying pattern[1:0] (GBRG=00, BGGR=01, GRBG=10, RGGB=11) and en.
REQ-007 SHALL have port rgb_video_i, axi4_stream_if.slave, -, carrying RGB input with G in [W-1:0], B in [2W-1:W] and R in [3W-1:2W], where W = RAW_PX_WIDTH.
REQ-008 SHALL have port raw_video_o, axi4_stream_if.master, -, carrying the Bayer output in tdata[W-1:0] with upper padding bits zero to the byte-rounded width.

Function
REQ-009 SHALL accept an input beat when tvalid && tready, with tuser marking frame start and tlast marking line end.
REQ-010 SHALL latch pattern and en on every accepted tuser beat; the latched values apply to that beat and all following beats until the next tuser.
REQ-011 SHALL track px_par and line_par:
  - px_par clears on a tuser beat, otherwise toggles per accepted beat, and clears after a tlast beat.
  - line_par clears on a tuser beat and toggles after each accepted tlast beat.
REQ-012 SHALL define line_is_r = pattern[1] ^ line_par and px_non_g = pattern[0] ^ px_par ^ line_par.
REQ-013 SHALL select the output sample when en is 1 as follows:
  - if px_non_g is 0, output G;
  - else if line_is_r is 1, output R;
  - else output B.
REQ-014 SHALL output the bypass value when en is 0, as defined under Configuration.
REQ-015 SHALL be a two-register pipeline (stage 1 registers the selection and partial sums, stage 2 is the output register), with latency of exactly 2 clk_i cycles from the accepting edge to raw_video_o.tvalid when no backpressure is applied.
REQ-016 SHALL support full backpressure:
  - a stage advances when its successor is empty or advancing;
  - rgb_video_i.tready = !stage1_valid || stage1_advances;
  - no beat is ever dropped or duplicated.
REQ-017 SHALL carry tlast and tuser through the pipeline aligned with their beat.
REQ-018 SHALL tie tkeep and tstrb to all ones and tid and tdest to 0.
REQ-019 SHALL hold raw_video_o tdata, tlast and tuser stable while tvalid && !tready.
REQ-020 SHALL apply control changes that occur mid-frame only at the next tuser beat.
REQ-021 SHALL restart parity on a tuser beat arriving mid-line, with no error flag raised.

Reset
REQ-022 SHALL, while rst_i is high, clear:
  - raw_video_o tvalid, tlast, tuser and tdata;
  - both pipeline valids, px_par and line_par;
  - the latched pattern (to GBRG) and the latched en (to 0).
REQ-023 SHALL discard in-flight beats when reset is asserted mid-frame; after release, beats preceding the first tuser use the reset-latched values (bypass, GBRG).
REQ-024 SHALL drive rgb_video_i.tready high in the first cycle after reset release.

Configuration
REQ-025 SHALL use the macro BAYER_MOSAICING_LUMA_EN to select the bypass value:
  - when defined, bypass output = (R + 2*G + B) >> 2, computed at W+2 bits, truncated, with the partial sum registered in stage 1;
  - when undefined, bypass output = G, and no adder logic is synthesized.

Structure
REQ-026 SHALL place the pattern constants (GBRG, BGGR, GRBG, RGGB) and a byte-rounding width function in shared package bayer_pkg, also imported by the demosaicing block.
REQ-027 SHALL implement the parity and latch logic (REQ-010 to REQ-012) in one sub-module, bayer_phase_tracker; the pipeline and selection stay in the top module.

Verification
REQ-028 SHALL cover, with W=10, RGGB, en=1 and a 4x2 frame of pixels R=0x300, G=0x200, B=0x100, no backpressure: output 0x300,0x200,0x300,0x200 / 0x200,0x100,0x200,0x100, each beat 2 cycles after acceptance, tuser on beat 0 and tlast on beats 3 and 7.
REQ-029 SHALL cover the same frame with GBRG, BGGR and GRBG: the first line is 0x200,0x100..., 0x100,0x200..., and 0x200,0x300... respectively.
REQ-030 SHALL cover en=0 with R=0x3FF, G=0x000, B=0x3FF: output 0x1FF when BAYER_MOSAICING_LUMA_EN is defined, else 0x000.
REQ-031 SHALL cover random tready at 50% with 1000 beats: the output sequence equals the zero-latency reference model, with no loss or duplicates and tdata stable during stalls.
REQ-032 SHALL cover a pattern change from RGGB to BGGR on line 1 of a frame: it is ignored until the next tuser, after which BGGR applies from beat 0.
REQ-033 SHALL cover rst_i asserted for 1 cycle while 2 beats are in flight: raw_video_o.tvalid is 0 the next cycle, and the next frame's output is correct.
